max_pool_engine: RTL and testbench

Parametrised 2-D pooling engine that reads a channel-major feature map from the conv2 output BRAM, reduces each POOL x POOL window, and writes the results to the flatten BRAM. It is the successor to the fixed 4-element, max-only pool layer. It adds configurable geometry and channel count, signed/unsigned data, a runtime max/average mode and full BRAM address generation. A single start pulse launches a run, and the engine handshakes with busy/done. It sits between the conv2 BRAM and the flatten BRAM in the clk_x5 domain.

---
 rtl/max_pool_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_max_pool_engine.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_engine.sv
// rtl/max_pool_engine.sv - POOLxPOOL max/average pooling engine between the conv2 and flatten BRAMs
// Streams one read per cycle, reduces each window in flight and writes one result per window.

module max_pool_engine #(
  parameter int BITWIDTH = 8,
  parameter int IN_W     = 16,
  parameter int IN_H     = 16,
  parameter int CHANNELS = 4,
  parameter int POOL     = 2,
  parameter int SIGNED   = 0,
  localparam int OW = IN_W / POOL,
  localparam int OH = IN_H / POOL,
  localparam int RA = ($clog2(CHANNELS * IN_W * IN_H) > 0) ? $clog2(CHANNELS * IN_W * IN_H) : 1,
  localparam int WA = ($clog2(CHANNELS * OW * OH) > 0) ? $clog2(CHANNELS * OW * OH) : 1
) (
  input  logic                clk_x5,
  input  logic                rstn,
  input  logic                start,
  input  logic                mode,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [RA-1:0]       rd_addr,
  input  logic [BITWIDTH-1:0] rd_data,
  output logic                wr_en,
  output logic [WA-1:0]       wr_addr,
  output logic [BITWIDTH-1:0] wr_data
);

  localparam int LP    = $clog2(POOL);
  localparam int SW    = BITWIDTH + 2 * LP;
  localparam int XW    = (OW > 1) ? $clog2(OW) : 1;
  localparam int YW    = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PLANE = IN_W * IN_H;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   mode_q, mode_d;

  logic [LP-1:0] wx_q, wx_d, wx_n;
  logic [LP-1:0] wy_q, wy_d, wy_n;
  logic [XW-1:0] ox_q, ox_d, ox_n;
  logic [YW-1:0] oy_q, oy_d, oy_n;
  logic [CW-1:0] ch_q, ch_d, ch_n;

  logic          rd_en_q, rd_en_d;
  logic [RA-1:0] rd_addr_q, rd_addr_d, addr_n;

  logic          vld_q, vld_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic [SW-1:0] acc_q, acc_d;

  logic                wr_en_q, wr_en_d;
  logic [WA-1:0]       wr_addr_q, wr_addr_d;
  logic [WA-1:0]       wr_idx_q, wr_idx_d;
  logic [BITWIDTH-1:0] wr_data_q, wr_data_d;

  logic wx_last, wy_last, ox_last, oy_last, ch_last;
  logic elem_last, run_last;

  logic                 sign_fill;
  logic [SW-1:0]        elem_ext;
  logic [SW-1:0]        acc_new;
  logic signed [SW-1:0] acc_s;
  logic [BITWIDTH-1:0]  avg;
  logic [BITWIDTH-1:0]  result;

  assign wx_last   = (wx_q == LP'(POOL - 1));
  assign wy_last   = (wy_q == LP'(POOL - 1));
  assign ox_last   = (ox_q == XW'(OW - 1));
  assign oy_last   = (oy_q == YW'(OH - 1));
  assign ch_last   = (ch_q == CW'(CHANNELS - 1));
  assign elem_last = wx_last && wy_last;
  assign run_last  = elem_last && ox_last && oy_last && ch_last;

  // Nested counter carry: window x, window y, ox, oy, channel.
  always_comb begin
    wx_n = wx_q;
    wy_n = wy_q;
    ox_n = ox_q;
    oy_n = oy_q;
    ch_n = ch_q;
    if (!wx_last) begin
      wx_n = wx_q + LP'(1);
    end else begin
      wx_n = '0;
      if (!wy_last) begin
        wy_n = wy_q + LP'(1);
      end else begin
        wy_n = '0;
        if (!ox_last) begin
          ox_n = ox_q + XW'(1);
        end else begin
          ox_n = '0;
          if (!oy_last) begin
            oy_n = oy_q + YW'(1);
          end else begin
            oy_n = '0;
            ch_n = ch_q + CW'(1);
          end
        end
      end
    end
  end

  assign addr_n = RA'(ch_n) * RA'(PLANE)
                + (RA'(oy_n) * RA'(POOL) + RA'(wy_n)) * RA'(IN_W)
                + RA'(ox_n) * RA'(POOL) + RA'(wx_n);

  // Widening by 2*LP bits keeps unsigned data positive, so one signed compare serves both modes.
  assign sign_fill = (SIGNED != 0) && rd_data[BITWIDTH-1];
  assign elem_ext  = {{(2 * LP){sign_fill}}, rd_data};

  always_comb begin
    acc_new = acc_q;
    if (first_q) begin
      acc_new = elem_ext;
    end else if (mode_q) begin
      acc_new = acc_q + elem_ext;
    end else if ($signed(elem_ext) > $signed(acc_q)) begin
      acc_new = elem_ext;
    end
  end

  assign acc_s  = acc_new;
  assign avg    = BITWIDTH'(acc_s >>> (2 * LP));
  assign result = mode_q ? avg : acc_new[BITWIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    ch_d      = ch_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    vld_d     = rd_en_q;
    first_d   = (wx_q == '0) && (wy_q == '0);
    last_d    = elem_last;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          mode_d    = mode;
          wx_d      = '0;
          wy_d      = '0;
          ox_d      = '0;
          oy_d      = '0;
          ch_d      = '0;
          wr_idx_d  = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      READ: begin
        if (run_last) begin
          state_d = DRAIN;
        end else begin
          wx_d      = wx_n;
          wy_d      = wy_n;
          ox_d      = ox_n;
          oy_d      = oy_n;
          ch_d      = ch_n;
          rd_en_d   = 1'b1;
          rd_addr_d = addr_n;
        end
      end
      DRAIN: begin
        // The last window's write is the one with no element still in flight.
        if (wr_en_q && !vld_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (vld_q) begin
      acc_d = acc_new;
      if (last_q) begin
        wr_en_d   = 1'b1;
        wr_data_d = result;
        wr_addr_d = wr_idx_q;
        wr_idx_d  = wr_idx_q + WA'(1);
      end
    end
  end

  always_ff @(posedge clk_x5 or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      wx_q      <= '0;
      wy_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      ch_q      <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      vld_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      ch_q      <= ch_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      vld_q     <= vld_d;
      first_q   <= first_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = (state_q == READ) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_max_pool_engine.sv
// tb/tb_max_pool_engine.sv - directed bench for max_pool_engine (small unsigned/signed and default geometry)

module tb_max_pool_engine;

  logic clk_x5 = 1'b0;
  always #5 clk_x5 = ~clk_x5;

  logic rstn;
  int   cyc = 0;
  always @(posedge clk_x5) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // A: 4x4x1 unsigned, B: 4x4x1 signed, C: default 16x16x4 unsigned.
  logic       a_start, a_mode, a_busy, a_done, a_rd_en, a_wr_en;
  logic [3:0] a_rd_addr;
  logic [1:0] a_wr_addr;
  logic [7:0] a_rd_data, a_wr_data;
  logic       b_start, b_mode, b_busy, b_done, b_rd_en, b_wr_en;
  logic [3:0] b_rd_addr;
  logic [1:0] b_wr_addr;
  logic [7:0] b_rd_data, b_wr_data;
  logic       c_start, c_mode, c_busy, c_done, c_rd_en, c_wr_en;
  logic [9:0] c_rd_addr;
  logic [7:0] c_wr_addr;
  logic [7:0] c_rd_data, c_wr_data;

  max_pool_engine #(.BITWIDTH(8), .IN_W(4), .IN_H(4), .CHANNELS(1), .POOL(2), .SIGNED(0)) u_a (
    .clk_x5(clk_x5), .rstn(rstn), .start(a_start), .mode(a_mode), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data));

  max_pool_engine #(.BITWIDTH(8), .IN_W(4), .IN_H(4), .CHANNELS(1), .POOL(2), .SIGNED(1)) u_b (
    .clk_x5(clk_x5), .rstn(rstn), .start(b_start), .mode(b_mode), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data));

  max_pool_engine u_c (
    .clk_x5(clk_x5), .rstn(rstn), .start(c_start), .mode(c_mode), .busy(c_busy), .done(c_done),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data));

  logic [7:0] ab_mem [16];
  logic [7:0] c_mem  [1024];

  always @(posedge clk_x5) begin
    if (a_rd_en) a_rd_data <= ab_mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= ab_mem[b_rd_addr];
    if (c_rd_en) c_rd_data <= c_mem[c_rd_addr];
  end

  function automatic logic [9:0] exp_rd_addr(input int j);
    int e, k;
    e = j % 4;
    k = j / 4;
    return 10'((k / 64) * 256 + (2 * ((k / 8) % 8) + e / 2) * 16 + 2 * (k % 8) + e % 2);
  endfunction

  function automatic logic [7:0] exp_c(input int k, input bit avg);
    return 8'(32 * ((k / 8) % 8) + 2 * (k % 8) + (avg ? 8 : 17));
  endfunction

  int         a_t0 = 0, b_t0 = 0, c_t0 = 0;
  logic [7:0] a_out [4];
  logic [7:0] b_out [4];
  logic [7:0] c_out [256];
  int         a_wcyc [4];
  int         a_nw = 0, b_nw = 0, c_nw = 0, c_base = 0;
  int         a_ndone = 0, b_ndone = 0, c_ndone = 0;
  int         a_done_cyc = 0, b_done_cyc = 0, c_done_cyc = 0;
  int         c_seq_err = 0, c_rd_err = 0, c_nrd = 0;

  always @(negedge clk_x5) begin
    if (a_wr_en) begin
      a_out[a_wr_addr]  <= a_wr_data;
      a_wcyc[a_wr_addr] <= cyc - a_t0;
      a_nw              <= a_nw + 1;
    end
    if (a_done) begin
      a_done_cyc <= cyc - a_t0;
      a_ndone    <= a_ndone + 1;
    end
    if (b_wr_en) begin
      b_out[b_wr_addr] <= b_wr_data;
      b_nw             <= b_nw + 1;
    end
    if (b_done) begin
      b_done_cyc <= cyc - b_t0;
      b_ndone    <= b_ndone + 1;
    end
    if (c_wr_en) begin
      c_out[c_wr_addr] <= c_wr_data;
      if (c_wr_addr != 8'(c_nw - c_base) || (cyc - c_t0) != 4 * (c_nw - c_base + 1) + 2)
        c_seq_err <= c_seq_err + 1;
      c_nw <= c_nw + 1;
    end
    if (c_rd_en) begin
      if (c_rd_addr !== exp_rd_addr(cyc - c_t0 - 1)) c_rd_err <= c_rd_err + 1;
      c_nrd <= c_nrd + 1;
    end
    if (c_done) begin
      c_done_cyc <= cyc - c_t0;
      c_ndone    <= c_ndone + 1;
    end
  end

  // Launch tasks are entered at a negedge, which becomes cycle 0.
  task automatic launch_a(input logic m);
    a_mode = m; a_start = 1'b1; a_t0 = cyc;
    @(negedge clk_x5);
    a_start = 1'b0;
  endtask

  task automatic launch_b(input logic m);
    b_mode = m; b_start = 1'b1; b_t0 = cyc;
    @(negedge clk_x5);
    b_start = 1'b0;
  endtask

  task automatic launch_c(input logic m);
    c_mode = m; c_start = 1'b1; c_t0 = cyc; c_base = c_nw;
    @(negedge clk_x5);
    c_start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit, output bit hit, output bit bz);
    hit = 1'b0;
    bz  = 1'b1;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk_x5);
      case (which)
        0:       begin hit = a_done; bz = a_busy; end
        1:       begin hit = b_done; bz = b_busy; end
        default: begin hit = c_done; bz = c_busy; end
      endcase
    end
    @(negedge clk_x5);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    a_start = 0; a_mode = 0; b_start = 0; b_mode = 0; c_start = 0; c_mode = 0;
    repeat (3) @(negedge clk_x5);
    checks++;
    if ({a_busy, a_done, a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, a_wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_a got=%h want=0", {a_busy, a_done, a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, a_wr_data});
    end
    checks++;
    if ({b_busy, b_done, b_rd_en, b_rd_addr, b_wr_en, b_wr_addr, b_wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_b got=%h want=0", {b_busy, b_done, b_rd_en, b_rd_addr, b_wr_en, b_wr_addr, b_wr_data});
    end
    checks++;
    if ({c_busy, c_done, c_rd_en, c_rd_addr, c_wr_en, c_wr_addr, c_wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_c got=%h want=0", {c_busy, c_done, c_rd_en, c_rd_addr, c_wr_en, c_wr_addr, c_wr_data});
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk_x5);
  endtask

  task automatic run_small_a(input logic m, input logic [31:0] want, input string name);
    bit hit, bz;
    int base;
    base = a_nw;
    launch_a(m);
    checks++;
    if ({a_busy, a_rd_en, a_rd_addr} !== 6'b11_0000) begin
      failures++;
      $display("FAIL %s_first_read got busy=%b rd_en=%b rd_addr=%0d want 1 1 0", name, a_busy, a_rd_en, a_rd_addr);
    end
    wait_done(0, 100, hit, bz);
    checks++;
    if (!hit || bz || a_done_cyc != 19) begin
      failures++;
      $display("FAIL %s_done got hit=%b busy=%b cycle=%0d want 1 0 19", name, hit, bz, a_done_cyc);
    end
    checks++;
    if (a_nw - base != 4) begin
      failures++;
      $display("FAIL %s_nwrites got=%0d want=4", name, a_nw - base);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_out[k] !== want[8*k +: 8] || a_wcyc[k] != 4 * (k + 1) + 2) begin
        failures++;
        $display("FAIL %s_win%0d got data=%0d cycle=%0d want data=%0d cycle=%0d",
                 name, k, a_out[k], a_wcyc[k], want[8*k +: 8], 4 * (k + 1) + 2);
      end
    end
    checks++;
    if (a_rd_addr !== 4'd15 || a_wr_addr !== 2'd3) begin
      failures++;
      $display("FAIL %s_hold_addr got rd=%0d wr=%0d want rd=15 wr=3", name, a_rd_addr, a_wr_addr);
    end
  endtask

  task automatic test_max_unsigned;
    for (int i = 0; i < 16; i++) ab_mem[i] = 8'(i);
    run_small_a(1'b0, {8'd15, 8'd13, 8'd7, 8'd5}, "max_u");
  endtask

  task automatic test_average;
    run_small_a(1'b1, {8'd12, 8'd10, 8'd4, 8'd2}, "avg_u");
  endtask

  task automatic test_sign;
    bit hit, bz;
    for (int i = 0; i < 16; i++) ab_mem[i] = 8'h00;
    ab_mem[0] = 8'h7F; ab_mem[1] = 8'h80; ab_mem[4] = 8'h01; ab_mem[5] = 8'h00;
    ab_mem[2] = 8'hFF; ab_mem[3] = 8'h80; ab_mem[6] = 8'hFD; ab_mem[7] = 8'hFC;
    launch_a(1'b0);
    wait_done(0, 100, hit, bz);
    checks++;
    if (!hit || a_out[0] !== 8'h80) begin
      failures++;
      $display("FAIL sign_max_unsigned got=%h want=80", a_out[0]);
    end
    launch_a(1'b1);
    wait_done(0, 100, hit, bz);
    checks++;
    if (!hit || a_out[0] !== 8'h40) begin
      failures++;
      $display("FAIL sign_avg_unsigned got=%h want=40", a_out[0]);
    end
    launch_b(1'b0);
    wait_done(1, 100, hit, bz);
    checks++;
    if (!hit || bz || b_done_cyc != 19 || b_out[0] !== 8'h7F) begin
      failures++;
      $display("FAIL sign_max_signed got=%h done_cycle=%0d want 7f 19", b_out[0], b_done_cyc);
    end
    launch_b(1'b1);
    wait_done(1, 100, hit, bz);
    checks++;
    if (!hit || b_out[1] !== 8'hDE || b_out[0] !== 8'h00) begin
      failures++;
      $display("FAIL sign_avg_signed got w0=%h w1=%h want 00 de", b_out[0], b_out[1]);
    end
  endtask

  task automatic check_c_run(input bit avg, input string name, input int seq0, input int rd0, input int nrd0,
                             input int ndone0);
    int bad, first_bad;
    checks++;
    if (c_done_cyc != 1027 || c_ndone - ndone0 != 1) begin
      failures++;
      $display("FAIL %s_done got cycle=%0d count=%0d want 1027 1", name, c_done_cyc, c_ndone - ndone0);
    end
    checks++;
    if (c_nw - c_base != 256 || c_seq_err != seq0) begin
      failures++;
      $display("FAIL %s_write_seq got writes=%0d order_errs=%0d want 256 0", name, c_nw - c_base, c_seq_err - seq0);
    end
    checks++;
    if (c_nrd - nrd0 != 1024 || c_rd_err != rd0) begin
      failures++;
      $display("FAIL %s_read_seq got reads=%0d addr_errs=%0d want 1024 0", name, c_nrd - nrd0, c_rd_err - rd0);
    end
    bad = 0;
    first_bad = -1;
    for (int k = 0; k < 256; k++) begin
      if (c_out[k] !== exp_c(k, avg)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_data got %0d bad windows, first addr=%0d data=%0d want=%0d", name, bad, first_bad,
               c_out[first_bad], exp_c(first_bad, avg));
    end
  endtask

  task automatic test_default;
    bit hit, bz;
    int seq0, rd0, nrd0, nd0;
    seq0 = c_seq_err; rd0 = c_rd_err; nrd0 = c_nrd; nd0 = c_ndone;
    launch_c(1'b0);
    wait_done(2, 1200, hit, bz);
    checks++;
    if (!hit || bz) begin
      failures++;
      $display("FAIL default_done_seen got hit=%b busy=%b want 1 0", hit, bz);
    end
    check_c_run(1'b0, "default", seq0, rd0, nrd0, nd0);
    checks++;
    if (c_out[0] !== 8'd17 || c_out[64] !== 8'd17) begin
      failures++;
      $display("FAIL default_addr0_64 got %0d %0d want 17 17", c_out[0], c_out[64]);
    end
    checks++;
    if (c_rd_addr !== 10'd1023 || c_wr_addr !== 8'd255) begin
      failures++;
      $display("FAIL default_hold_addr got rd=%0d wr=%0d want 1023 255", c_rd_addr, c_wr_addr);
    end
  endtask

  task automatic test_back_to_back;
    bit hit, bz;
    int seq0, rd0, nrd0, nd0;
    seq0 = c_seq_err; rd0 = c_rd_err; nrd0 = c_nrd; nd0 = c_ndone;
    launch_c(1'b0);
    repeat (99) @(negedge clk_x5);
    c_start = 1'b1;
    c_mode  = 1'b1;
    @(negedge clk_x5);
    c_start = 1'b0;
    wait_done(2, 1200, hit, bz);
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL midrun_done_seen got=0 want=1");
    end
    check_c_run(1'b0, "midrun", seq0, rd0, nrd0, nd0);
    seq0 = c_seq_err; rd0 = c_rd_err; nrd0 = c_nrd; nd0 = c_ndone;
    launch_c(1'b1);
    wait_done(2, 1200, hit, bz);
    check_c_run(1'b1, "b2b_avg", seq0, rd0, nrd0, nd0);
  endtask

  task automatic test_reset_midrun;
    bit hit, bz;
    int nw_snap, nd_snap, seq0, rd0, nrd0, nd0;
    launch_c(1'b0);
    repeat (49) @(negedge clk_x5);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({c_busy, c_done, c_rd_en, c_rd_addr, c_wr_en, c_wr_addr, c_wr_data} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%h want=0", {c_busy, c_done, c_rd_en, c_rd_addr, c_wr_en, c_wr_addr, c_wr_data});
    end
    nw_snap = c_nw;
    nd_snap = c_ndone;
    checks++;
    if (nw_snap - c_base != 12) begin
      failures++;
      $display("FAIL rst_mid_prior_writes got=%0d want=12", nw_snap - c_base);
    end
    repeat (3) @(negedge clk_x5);
    rstn = 1'b1;
    repeat (10) @(negedge clk_x5);
    checks++;
    if (c_nw != nw_snap || c_ndone != nd_snap || c_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_quiet got writes=%0d done=%0d busy=%b want 0 0 0", c_nw - nw_snap, c_ndone - nd_snap, c_busy);
    end
    seq0 = c_seq_err; rd0 = c_rd_err; nrd0 = c_nrd; nd0 = c_ndone;
    launch_c(1'b0);
    wait_done(2, 1200, hit, bz);
    check_c_run(1'b0, "rst_rerun", seq0, rd0, nrd0, nd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) c_mem[i] = 8'(i);
    for (int i = 0; i < 16; i++) ab_mem[i] = 8'h00;
    test_reset;
    test_max_unsigned;
    test_average;
    test_sign;
    test_default;
    test_back_to_back;
    test_reset_midrun;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
